ram_port_arbiter: RTL and testbench

//  Shares the single-port data RAM (LDA/STA/LDB/STB path) between two requesters:

---
 rtl/ram_port_arbiter_pkg.sv | 17 +
 rtl/ram_port_arbiter_rr_select2.sv | 24 ++
 rtl/ram_port_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: state codes, port ids
// and the default RAM geometry used by Ram and cpu_top.
package ram_port_arbiter_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;

    localparam logic OWNER_C = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_RESP   = 2'b10
    } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_select2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes
// to the port that did not own the previous transaction.
module rr_select2
    import ram_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick the winner from the request pair and the previous owner
    always_comb begin
        gnt_valid = |req;
        gnt_id    = OWNER_C;
        case (req)
            2'b01:   gnt_id = OWNER_C;
            2'b10:   gnt_id = OWNER_D;
            2'b11:   gnt_id = ~last;
            default: gnt_id = OWNER_C;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the CPU (port C) and the
// debug/program-loader host (port D). One access at a time, req/ack
// handshake, round-robin on ties, stall to the CPU while it waits.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              owner,
    output logic              busy
);

    arb_state_t        state;
    logic              last_owner;
    logic              lat_we;
    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_select2 u_rr_select2 (
        .req       ({d_req, c_req}),
        .last      (last_owner),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Route the winning port's request fields to the latch inputs
    always_comb begin
        sel_we    = c_we;
        sel_addr  = c_addr;
        sel_wdata = c_wdata;
        if (gnt_id == OWNER_D) begin
            sel_we    = d_we;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
    end

    // Arbitration FSM with registered RAM strobes, acks and read-data returns;
    // the strobes are set on the IDLE->ACCESS edge so they are high exactly in ACCESS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            last_owner <= OWNER_D;
            owner      <= OWNER_C;
            lat_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            c_ack      <= 1'b0;
            d_ack      <= 1'b0;
            c_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            ram_we <= 1'b0;
            ram_re <= 1'b0;
            c_ack  <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        owner     <= gnt_id;
                        lat_we    <= sel_we;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        ram_we    <= sel_we;
                        ram_re    <= ~sel_we;
                        state     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (!lat_we) begin
                        if (owner == OWNER_D) begin
                            d_rdata <= ram_rdata;
                        end else begin
                            c_rdata <= ram_rdata;
                        end
                    end
                    c_ack <= (owner == OWNER_C);
                    d_ack <= (owner == OWNER_D);
                    state <= ARB_RESP;
                end
                ARB_RESP: begin
                    last_owner <= owner;
                    state      <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != ARB_IDLE);
    assign c_stall = c_req & ~c_ack;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level reference model.
module tb_ram_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_ack, d_ack, c_stall;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          ram_we, ram_re, owner, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_ack     (c_ack),
        .c_rdata   (c_rdata),
        .c_stall   (c_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .owner     (owner),
        .busy      (busy)
    );

    // Environment RAM: combinational read, write on the clock edge
    logic [DW-1:0] env_mem [16];
    assign ram_rdata = env_mem[ram_addr];
    always @(posedge clk) if (ram_we === 1'b1) env_mem[ram_addr] <= ram_wdata;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    txn_t c_q[$];
    txn_t d_q[$];
    bit   c_b2b, d_b2b;
    bit   c_ack_seen, d_ack_seen;
    int   ack_port[$];
    int   ack_cyc[$];

    // Reference model: one transaction record, timed relative to its grant cycle
    logic [DW-1:0] mmem [16];
    bit            m_active;
    int            m_gc;
    bit            m_port;
    txn_t          m_t;
    bit            m_last;
    bit            m_owner;
    logic [AW-1:0] m_laddr;
    logic [DW-1:0] m_lwdata;
    logic [DW-1:0] m_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_last   = 1'b1;
        m_owner  = 1'b0;
        m_laddr  = '0;
        m_lwdata = '0;
        m_rd[0]  = '0;
        m_rd[1]  = '0;
    endtask

    // Requester behaviour: hold req until ack, then drop for a cycle unless back-to-back
    task automatic drive_inputs();
        bit drop;
        drop = 1'b0;
        if (c_req && c_ack_seen) begin
            c_q.delete(0);
            drop = !c_b2b;
        end
        if (drop || c_q.size() == 0) c_req = 1'b0;
        else begin
            c_req = 1'b1; c_we = c_q[0].we; c_addr = c_q[0].addr; c_wdata = c_q[0].wdata;
        end
        drop = 1'b0;
        if (d_req && d_ack_seen) begin
            d_q.delete(0);
            drop = !d_b2b;
        end
        if (drop || d_q.size() == 0) d_req = 1'b0;
        else begin
            d_req = 1'b1; d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
        end
    endtask

    task automatic cycle();
        int d;
        bit e_cack, e_dack;
        #1;
        d      = m_active ? (cyc - m_gc) : 99;
        e_cack = (d == 2) && !m_port;
        e_dack = (d == 2) && m_port;
        chk("busy",      32'(busy),      32'(d == 1 || d == 2));
        chk("ram_we",    32'(ram_we),    32'(d == 1 && m_t.we));
        chk("ram_re",    32'(ram_re),    32'(d == 1 && !m_t.we));
        chk("ram_addr",  32'(ram_addr),  32'(m_laddr));
        chk("ram_wdata", 32'(ram_wdata), 32'(m_lwdata));
        chk("owner",     32'(owner),     32'(m_owner));
        chk("c_ack",     32'(c_ack),     32'(e_cack));
        chk("d_ack",     32'(d_ack),     32'(e_dack));
        chk("c_rdata",   32'(c_rdata),   32'(m_rd[0]));
        chk("d_rdata",   32'(d_rdata),   32'(m_rd[1]));
        chk("c_stall",   32'(c_stall),   32'(c_req & ~e_cack));
        c_ack_seen = (c_ack === 1'b1);
        d_ack_seen = (d_ack === 1'b1);
        if (c_ack_seen) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
        if (d_ack_seen) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
        if (d == 1) begin
            if (m_t.we) mmem[m_t.addr] = m_t.wdata;
            else        m_rd[m_port] = mmem[m_t.addr];
        end
        if (d == 2) m_last = m_port;
        if (d >= 3 && (c_req || d_req)) begin
            m_port   = (c_req && d_req) ? !m_last : d_req;
            m_t      = m_port ? txn_t'{d_we, d_addr, d_wdata} : txn_t'{c_we, c_addr, c_wdata};
            m_active = 1'b1;
            m_gc     = cyc;
            m_owner  = m_port;
            m_laddr  = m_t.addr;
            m_lwdata = m_t.wdata;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        drive_inputs();
    endtask

    task automatic run(input int budget);
        int left;
        bit done;
        left = budget;
        done = 1'b0;
        while (!done && left > 0) begin
            cycle();
            left--;
            done = (c_q.size() == 0) && (d_q.size() == 0) && !c_req && !d_req &&
                   (!m_active || (cyc - m_gc) >= 3);
        end
        chk("drain", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        c_req = 1'b0;
        d_req = 1'b0;
        c_q.delete();
        d_q.delete();
        c_ack_seen = 1'b0;
        d_ack_seen = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = 4'($urandom_range(0, 15));
        t.wdata = 8'($urandom_range(0, 255));
        return t;
    endfunction

    initial begin
        int base;
        int pushed;
        reset = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        c_b2b = 1'b0; d_b2b = 1'b0;
        c_ack_seen = 1'b0; d_ack_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = 8'($urandom_range(0, 255));
            mmem[i]    = env_mem[i];
        end
        env_mem[3] = 8'hA5;
        mmem[3]    = 8'hA5;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_owner",   32'(owner),    32'd0);
        chk("rst_ram_we",  32'(ram_we),   32'd0);
        chk("rst_ram_re",  32'(ram_re),   32'd0);
        chk("rst_c_rdata", 32'(c_rdata),  32'd0);
        chk("rst_ram_addr",32'(ram_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Test 1: single C read of address 3
        c_q.push_back(txn_t'{1'b0, 4'h3, 8'h00});
        drive_inputs();
        base = cyc;
        run(20);
        chk("t1_c_rdata", 32'(c_rdata), 32'h A5);
        chk("t1_ack_cyc", 32'(ack_cyc.size() > 0 ? ack_cyc[0] - base : -1), 32'd2);

        // Test 2: D write 7/3C, then C read of address 7
        ack_port.delete(); ack_cyc.delete();
        d_q.push_back(txn_t'{1'b1, 4'h7, 8'h3C});
        drive_inputs();
        run(20);
        c_q.push_back(txn_t'{1'b0, 4'h7, 8'h00});
        drive_inputs();
        run(20);
        chk("t2_c_rdata", 32'(c_rdata), 32'h3C);
        chk("t2_d_rdata", 32'(d_rdata), 32'h00);

        // Test 3: simultaneous back-to-back requests after reset
        do_reset();
        ack_port.delete(); ack_cyc.delete();
        c_b2b = 1'b1; d_b2b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            c_q.push_back(txn_t'{1'b0, 4'(i), 8'h00});
            d_q.push_back(txn_t'{1'b0, 4'(i + 8), 8'h00});
        end
        drive_inputs();
        base = cyc;
        run(40);
        chk("t3_n_acks", 32'(ack_port.size()), 32'd4);
        if (ack_port.size() == 4) begin
            chk("t3_order0", 32'(ack_port[0]), 32'd0);
            chk("t3_order1", 32'(ack_port[1]), 32'd1);
            chk("t3_order2", 32'(ack_port[2]), 32'd0);
            chk("t3_order3", 32'(ack_port[3]), 32'd1);
            chk("t3_c_cyc",  32'(ack_cyc[0] - base), 32'd2);
            chk("t3_d_cyc",  32'(ack_cyc[1] - base), 32'd5);
        end

        // Test 4: C streams back-to-back, D arrives while C is busy
        ack_port.delete(); ack_cyc.delete();
        c_b2b = 1'b1; d_b2b = 1'b0;
        for (int i = 0; i < 3; i++) c_q.push_back(txn_t'{1'b0, 4'(i + 2), 8'h00});
        drive_inputs();
        cycle();
        cycle();
        d_q.push_back(txn_t'{1'b0, 4'hE, 8'h00});
        run(40);
        chk("t4_n_acks", 32'(ack_port.size()), 32'd4);
        if (ack_port.size() == 4) begin
            chk("t4_order0", 32'(ack_port[0]), 32'd0);
            chk("t4_order1", 32'(ack_port[1]), 32'd1);
            chk("t4_order2", 32'(ack_port[2]), 32'd0);
            chk("t4_order3", 32'(ack_port[3]), 32'd0);
        end

        // Test 6: c_addr changes during ACCESS
        ack_port.delete(); ack_cyc.delete();
        c_b2b = 1'b0;
        c_q.push_back(txn_t'{1'b0, 4'h1, 8'h00});
        drive_inputs();
        cycle();
        c_addr = 4'h9;
        #1;
        chk("t6_ram_addr", 32'(ram_addr), 32'h1);
        run(20);
        chk("t6_n_acks", 32'(ack_port.size()), 32'd1);

        // Test 5: reset asserted during ACCESS of a D write
        ack_port.delete(); ack_cyc.delete();
        d_b2b = 1'b0;
        d_q.push_back(txn_t'{1'b1, 4'h5, 8'h5A});
        drive_inputs();
        cycle();
        #1;
        chk("t5_pre_we", 32'(ram_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_ram_we",   32'(ram_we),    32'd0);
        chk("t5_ram_re",   32'(ram_re),    32'd0);
        chk("t5_busy",     32'(busy),      32'd0);
        chk("t5_owner",    32'(owner),     32'd0);
        chk("t5_d_ack",    32'(d_ack),     32'd0);
        chk("t5_ram_addr", 32'(ram_addr),  32'd0);
        chk("t5_wdata",    32'(ram_wdata), 32'd0);
        chk("t5_c_rdata",  32'(c_rdata),   32'd0);
        chk("t5_d_rdata",  32'(d_rdata),   32'd0);
        model_reset();
        d_q.delete();
        d_req = 1'b0;
        c_ack_seen = 1'b0;
        d_ack_seen = 1'b0;
        c_q.push_back(txn_t'{1'b0, 4'h5, 8'h00});
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("t5_hold_d_ack", 32'(d_ack), 32'd0);
        reset = 1'b1;
        base = cyc;
        run(20);
        chk("t5_c_ack_cyc", 32'(ack_cyc.size() > 0 ? ack_cyc[0] - base : -1), 32'd2);
        chk("t5_no_d_ack",  32'(ack_port.size() > 0 ? ack_port[0] : -1), 32'd0);

        // Random traffic from both ports
        do_reset();
        ack_port.delete(); ack_cyc.delete();
        pushed = 0;
        for (int i = 0; i < 600; i++) begin
            if (c_q.size() < 2 && $urandom_range(0, 3) == 0) begin c_q.push_back(rand_txn()); pushed++; end
            if (d_q.size() < 2 && $urandom_range(0, 3) == 0) begin d_q.push_back(rand_txn()); pushed++; end
            if ($urandom_range(0, 15) == 0) c_b2b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) d_b2b = 1'($urandom_range(0, 1));
            cycle();
        end
        run(200);
        chk("rand_n_acks", 32'(ack_port.size()), 32'(pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
